// File: rtl/melody_pkg.sv
// Shared constants, FSM state encoding and melody slot helper for melody_writer.
package melody_pkg;

   localparam int          NOTE_BITS = 3;
   localparam int          SLOT_BITS = 4;
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE     = 3'd0;
   localparam state_t S_GEN      = 3'd1;
   localparam state_t S_WRITE    = 3'd2;
   localparam state_t S_GAP      = 3'd3;
   localparam state_t S_START    = 3'd4;
   localparam state_t S_WAIT_END = 3'd5;

   // Places a note in slot idx of the melody word; the slot's top bit is always 0.
   function automatic logic [31:0] slot_insert(input logic [31:0]          word,
                                               input int                   idx,
                                               input logic [NOTE_BITS-1:0] note);
      logic [31:0] r;
      r = word;
      r[idx*SLOT_BITS +: SLOT_BITS] = {1'b0, note};
      return r;
   endfunction

endpackage

// File: rtl/melody_lfsr.sv
// 16-bit right-shifting Galois LFSR with seed load (zero seed forced to 1) and advance enable.
module melody_lfsr
   import melody_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [15:0]          seed,
   input  logic                 advance,
   output logic [NOTE_BITS-1:0] note
);

   logic [15:0] value;

   // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value <= SEED;
      else if (load)
         value <= (seed == 16'h0000) ? 16'h0001 : seed;
      else if (advance)
         value <= (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
   end

   assign note = value[NOTE_BITS-1:0];

endmodule

// File: rtl/melody_writer.sv
// Generates a pseudo-random melody, writes it to the game module and starts a round.
// Optional: define MELODY_NO_REPEAT_EN to bump a note that repeats its predecessor.
module melody_writer
   import melody_pkg::*;
#(
   parameter int          NOTE_COUNT = 8,
   parameter logic [15:0] LFSR_SEED  = 16'hACE1,
   parameter int          START_GAP  = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        new_game,
   input  logic [15:0] seed_in,
   input  logic        seed_load,
   input  logic        abort,
   input  logic        game_end,
   output logic [31:0] data_out,
   output logic        write_enable,
   output logic        game_start,
   output logic        busy,
   output logic [7:0]  round_count
);

   localparam int               IDX_W    = $clog2(NOTE_COUNT);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NOTE_COUNT - 1);
   localparam logic [3:0]       GAP_LAST = 4'(START_GAP - 1);

   state_t               state;
   logic [IDX_W-1:0]     note_idx;
   logic [3:0]           gap_cnt;
   logic [31:0]          shadow;
   logic                 game_end_q;
   logic [NOTE_BITS-1:0] raw_note;
   logic [NOTE_BITS-1:0] note;
   logic                 lfsr_load;
   logic                 lfsr_advance;

   assign lfsr_load    = (state == S_IDLE) && seed_load;
   assign lfsr_advance = (state == S_GEN) && !abort;
   assign busy         = (state != S_IDLE);

   melody_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load    (lfsr_load),
      .seed    (seed_in),
      .advance (lfsr_advance),
      .note    (raw_note)
   );

`ifdef MELODY_NO_REPEAT_EN
   logic [NOTE_BITS-1:0] prev_note;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prev_note <= '0;
      else if (state == S_GEN)
         prev_note <= note;
   end

   // NOTE: assign a default first in always_comb so no path leaves the output unassigned (latch).
   always_comb begin
      note = raw_note;
      if (note_idx != '0 && raw_note == prev_note)
         note = raw_note + 1'b1;
   end
`else
   always_comb begin
      note = raw_note;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         note_idx     <= '0;
         gap_cnt      <= '0;
         shadow       <= '0;
         game_end_q   <= 1'b0;
         data_out     <= '0;
         write_enable <= 1'b0;
         game_start   <= 1'b0;
         round_count  <= '0;
      end else begin
         game_end_q   <= game_end;
         // Strobes default low each cycle so each one lasts exactly one clock.
         write_enable <= 1'b0;
         game_start   <= 1'b0;
         if (abort) begin
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (new_game && !seed_load) begin
                     state    <= S_GEN;
                     note_idx <= '0;
                     shadow   <= '0;
                  end
               end
               S_GEN: begin
                  shadow   <= slot_insert(shadow, int'(note_idx), note);
                  note_idx <= note_idx + 1'b1;
                  if (note_idx == LAST_IDX)
                     state <= S_WRITE;
               end
               S_WRITE: begin
                  data_out     <= shadow;
                  write_enable <= 1'b1;
                  gap_cnt      <= '0;
                  state        <= S_GAP;
               end
               S_GAP: begin
                  if (gap_cnt == GAP_LAST)
                     state <= S_START;
                  else
                     gap_cnt <= gap_cnt + 4'd1;
               end
               S_START: begin
                  game_start <= 1'b1;
                  state      <= S_WAIT_END;
               end
               S_WAIT_END: begin
                  // game_end held high from a previous round does not look like an edge.
                  if (game_end && !game_end_q) begin
                     if (round_count != 8'hFF)
                        round_count <= round_count + 8'd1;
                     state <= S_IDLE;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
